// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the unified word memory.
// The arbiter sits on the slave side; requesters and memory drive the master side.
interface mem_arbiter_if;
   logic        IF_REQ;
   logic [15:0] IF_A;
   logic        IF_GNT;
   logic        IF_RVALID;
   logic [15:0] IF_RD;
   logic        IF_ERR;
   logic        D_REQ;
   logic        D_WE;
   logic [15:0] D_A;
   logic [15:0] D_WD;
   logic        D_GNT;
   logic        D_RVALID;
   logic [15:0] D_RD;
   logic        D_ERR;
   logic [15:0] MEM_A;
   logic [15:0] MEM_WD;
   logic        MEM_WE;
   logic [15:0] MEM_RD;

   modport slave (
      input  IF_REQ, IF_A, D_REQ, D_WE, D_A, D_WD, MEM_RD,
      output IF_GNT, IF_RVALID, IF_RD, IF_ERR, D_GNT, D_RVALID, D_RD, D_ERR,
             MEM_A, MEM_WD, MEM_WE
   );
   modport master (
      output IF_REQ, IF_A, D_REQ, D_WE, D_A, D_WD, MEM_RD,
      input  IF_GNT, IF_RVALID, IF_RD, IF_ERR, D_GNT, D_RVALID, D_RD, D_ERR,
             MEM_A, MEM_WD, MEM_WE
   );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/load-store arbiter for the single-port word memory: data priority with a
// fetch starvation guard, range/write-protect checks, response routed one cycle later.
module mem_arbiter #(
   parameter int STARVE_MAX = 3,
   parameter bit TEXT_WP    = 1'b1
) (
   input logic          CLK,
   input logic          RST,
   mem_arbiter_if.slave bus
);
   localparam logic [3:0] LP_STARVE = 4'(STARVE_MAX);

   logic [3:0] r_starve;
   logic       r_pend_if, r_pend_d, r_pend_err, r_pend_wr;
   logic       w_if_err, w_d_err, w_if_win, w_d_win, w_gnt_err;

   always_comb begin
      w_if_err  = bus.IF_A > 16'h8000;
      w_d_err   = (bus.D_A > 16'h8000) | (TEXT_WP & bus.D_WE & (bus.D_A <= 16'h2000));
      // Grants are masked while reset is held so nothing reaches the memory port.
      w_if_win  = ~RST & bus.IF_REQ & (~bus.D_REQ | (r_starve == LP_STARVE));
      w_d_win   = ~RST & bus.D_REQ & ~w_if_win;
      w_gnt_err = (w_if_win & w_if_err) | (w_d_win & w_d_err);
   end

   assign bus.IF_GNT = w_if_win;
   assign bus.D_GNT  = w_d_win;
   assign bus.MEM_A  = w_if_win ? bus.IF_A : (w_d_win ? bus.D_A : 16'h0000);
   assign bus.MEM_WD = w_d_win ? bus.D_WD : 16'h0000;
   assign bus.MEM_WE = w_d_win & bus.D_WE & ~w_d_err;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_starve <= 4'd0;
      end else if (bus.IF_REQ & ~w_if_win) begin
         r_starve <= (r_starve == LP_STARVE) ? r_starve : r_starve + 4'd1;
      end else begin
         r_starve <= 4'd0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_pend_if  <= 1'b0;
         r_pend_d   <= 1'b0;
         r_pend_err <= 1'b0;
         r_pend_wr  <= 1'b0;
      end else begin
         r_pend_if  <= w_if_win;
         r_pend_d   <= w_d_win;
         r_pend_err <= w_gnt_err;
         r_pend_wr  <= w_d_win & bus.D_WE;
      end
   end

   // Read data is only forwarded for clean reads; errors and write acks return 0.
   assign bus.IF_RVALID = r_pend_if;
   assign bus.IF_ERR    = r_pend_if & r_pend_err;
   assign bus.IF_RD     = (r_pend_if & ~r_pend_err) ? bus.MEM_RD : 16'h0000;
   assign bus.D_RVALID  = r_pend_d;
   assign bus.D_ERR     = r_pend_d & r_pend_err;
   assign bus.D_RD      = (r_pend_d & ~r_pend_err & ~r_pend_wr) ? bus.MEM_RD : 16'h0000;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a
// cycle-level reference of the arbitration and memory rules.
module tb_mem_arbiter;
   localparam int STARVE_MAX = 3;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   n_vec = 0;
   int   n_mis = 0;

   mem_arbiter_if bus();
   mem_arbiter #(.STARVE_MAX(STARVE_MAX), .TEXT_WP(1'b1)) dut (.CLK(CLK), .RST(RST), .bus(bus));

   always #5 CLK = ~CLK;

   // Memory contents start from a deterministic pattern; only written entries are stored.
   logic [15:0] mem     [logic [15:0]];
   logic [15:0] ref_mem [logic [15:0]];

   function automatic logic [15:0] init_val(logic [15:0] a);
      return (a * 16'd7) ^ 16'h5A3C;
   endfunction
   function automatic logic [15:0] mem_rd(logic [15:0] a);
      return mem.exists(a) ? mem[a] : init_val(a);
   endfunction
   function automatic logic [15:0] ref_rd(logic [15:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   always @(posedge CLK) begin
      bus.MEM_RD <= mem_rd(bus.MEM_A);
      if (bus.MEM_WE) mem[bus.MEM_A] = bus.MEM_WD;
   end

   task automatic drive(input bit ir, input logic [15:0] ia, input bit dr, input bit dwe,
                        input logic [15:0] da, input logic [15:0] dwd);
      bus.IF_REQ = ir; bus.IF_A = ia;
      bus.D_REQ = dr; bus.D_WE = dwe; bus.D_A = da; bus.D_WD = dwd;
   endtask

   task automatic test_reset;
      drive(1, 16'h0010, 1, 0, 16'h4000, 16'h0);
      @(negedge CLK); #1;
      n_vec++; if (bus.IF_GNT !== 1'b0 || bus.D_GNT !== 1'b0) begin n_mis++; $display("FAIL reset_gnt if=%b d=%b exp 0 0", bus.IF_GNT, bus.D_GNT); end
      n_vec++; if (bus.MEM_WE !== 1'b0 || bus.MEM_A !== 16'h0) begin n_mis++; $display("FAIL reset_mem we=%b a=%h exp 0 0000", bus.MEM_WE, bus.MEM_A); end
      n_vec++; if (bus.IF_RVALID !== 1'b0 || bus.D_RVALID !== 1'b0 || bus.IF_RD !== 16'h0 || bus.D_RD !== 16'h0) begin
         n_mis++; $display("FAIL reset_resp ifv=%b dv=%b ifrd=%h drd=%h exp all 0", bus.IF_RVALID, bus.D_RVALID, bus.IF_RD, bus.D_RD); end
      @(negedge CLK); RST = 1'b0; #1;
      n_vec++; if (bus.D_GNT !== 1'b1 || bus.IF_GNT !== 1'b0) begin n_mis++; $display("FAIL release_gnt d=%b if=%b exp 1 0", bus.D_GNT, bus.IF_GNT); end
      @(negedge CLK); drive(0, 0, 0, 0, 0, 0); #1;
      n_vec++; if (bus.D_RVALID !== 1'b1 || bus.D_RD !== init_val(16'h4000)) begin
         n_mis++; $display("FAIL release_resp dv=%b rd=%h exp 1 %h", bus.D_RVALID, bus.D_RD, init_val(16'h4000)); end
      @(negedge CLK);
   endtask

   task automatic test_write_read;
      drive(0, 0, 1, 1, 16'h3000, 16'hBEEF); #1;
      n_vec++; if (bus.D_GNT !== 1'b1 || bus.MEM_WE !== 1'b1 || bus.MEM_A !== 16'h3000 || bus.MEM_WD !== 16'hBEEF) begin
         n_mis++; $display("FAIL wr_grant gnt=%b we=%b a=%h wd=%h exp 1 1 3000 beef", bus.D_GNT, bus.MEM_WE, bus.MEM_A, bus.MEM_WD); end
      ref_mem[16'h3000] = 16'hBEEF;
      @(negedge CLK); drive(0, 0, 1, 0, 16'h3000, 16'h0); #1;
      n_vec++; if (bus.D_RVALID !== 1'b1 || bus.D_ERR !== 1'b0 || bus.D_RD !== 16'h0) begin
         n_mis++; $display("FAIL wr_ack v=%b err=%b rd=%h exp 1 0 0000", bus.D_RVALID, bus.D_ERR, bus.D_RD); end
      @(negedge CLK); drive(0, 0, 0, 0, 0, 0); #1;
      n_vec++; if (bus.D_RVALID !== 1'b1 || bus.D_RD !== 16'hBEEF) begin
         n_mis++; $display("FAIL rd_back v=%b rd=%h exp 1 beef", bus.D_RVALID, bus.D_RD); end
      @(negedge CLK);
   endtask

   task automatic test_starvation;
      bit prev_if;
      prev_if = 1'b0;
      drive(1, 16'h0010, 1, 0, 16'h4000, 16'h0);
      for (int k = 0; k < 9; k++) begin
         if (k == 8) drive(0, 0, 0, 0, 0, 0);
         #1;
         if (k > 0) begin
            n_vec++;
            if (prev_if ? (bus.IF_RVALID !== 1'b1 || bus.IF_RD !== init_val(16'h0010))
                        : (bus.D_RVALID !== 1'b1 || bus.D_RD !== init_val(16'h4000))) begin
               n_mis++; $display("FAIL starve_resp k=%0d ifv=%b ifrd=%h dv=%b drd=%h exp_if=%b", k, bus.IF_RVALID, bus.IF_RD, bus.D_RVALID, bus.D_RD, prev_if); end
         end
         if (k < 8) begin
            n_vec++;
            if (bus.IF_GNT !== (k % 4 == 3) || bus.D_GNT !== (k % 4 != 3)) begin
               n_mis++; $display("FAIL starve_gnt k=%0d if=%b d=%b exp if=%b", k, bus.IF_GNT, bus.D_GNT, (k % 4 == 3)); end
            prev_if = (k % 4 == 3);
         end
         @(negedge CLK);
      end
   endtask

   task automatic test_errors;
      drive(0, 0, 1, 1, 16'h1000, 16'h1234); #1;
      n_vec++; if (bus.D_GNT !== 1'b1 || bus.MEM_WE !== 1'b0) begin n_mis++; $display("FAIL wp_grant gnt=%b we=%b exp 1 0", bus.D_GNT, bus.MEM_WE); end
      @(negedge CLK); drive(0, 0, 1, 0, 16'h1000, 0); #1;
      n_vec++; if (bus.D_RVALID !== 1'b1 || bus.D_ERR !== 1'b1 || bus.D_RD !== 16'h0) begin
         n_mis++; $display("FAIL wp_resp v=%b err=%b rd=%h exp 1 1 0000", bus.D_RVALID, bus.D_ERR, bus.D_RD); end
      @(negedge CLK); drive(1, 16'h8001, 0, 0, 0, 0); #1;
      n_vec++; if (bus.D_ERR !== 1'b0 || bus.D_RD !== init_val(16'h1000)) begin
         n_mis++; $display("FAIL wp_readback err=%b rd=%h exp 0 %h", bus.D_ERR, bus.D_RD, init_val(16'h1000)); end
      n_vec++; if (bus.IF_GNT !== 1'b1) begin n_mis++; $display("FAIL if_oor_gnt gnt=%b exp 1", bus.IF_GNT); end
      @(negedge CLK); drive(0, 0, 1, 0, 16'h8000, 0); #1;
      n_vec++; if (bus.IF_RVALID !== 1'b1 || bus.IF_ERR !== 1'b1 || bus.IF_RD !== 16'h0) begin
         n_mis++; $display("FAIL if_oor_resp v=%b err=%b rd=%h exp 1 1 0000", bus.IF_RVALID, bus.IF_ERR, bus.IF_RD); end
      @(negedge CLK); drive(0, 0, 1, 1, 16'h2000, 16'h5555); #1;
      n_vec++; if (bus.D_RVALID !== 1'b1 || bus.D_ERR !== 1'b0 || bus.D_RD !== init_val(16'h8000)) begin
         n_mis++; $display("FAIL d_8000 v=%b err=%b rd=%h exp 1 0 %h", bus.D_RVALID, bus.D_ERR, bus.D_RD, init_val(16'h8000)); end
      n_vec++; if (bus.MEM_WE !== 1'b0) begin n_mis++; $display("FAIL wp_2000 we=%b exp 0", bus.MEM_WE); end
      @(negedge CLK); drive(0, 0, 1, 1, 16'h2001, 16'h0F0F); #1;
      n_vec++; if (bus.D_ERR !== 1'b1) begin n_mis++; $display("FAIL wp_2000_err err=%b exp 1", bus.D_ERR); end
      n_vec++; if (bus.MEM_WE !== 1'b1) begin n_mis++; $display("FAIL wr_2001 we=%b exp 1", bus.MEM_WE); end
      ref_mem[16'h2001] = 16'h0F0F;
      @(negedge CLK); drive(0, 0, 0, 0, 0, 0); #1;
      n_vec++; if (bus.D_RVALID !== 1'b1 || bus.D_ERR !== 1'b0 || bus.D_RD !== 16'h0) begin
         n_mis++; $display("FAIL wr_2001_ack v=%b err=%b rd=%h exp 1 0 0000", bus.D_RVALID, bus.D_ERR, bus.D_RD); end
      @(negedge CLK);
   endtask

   task automatic test_reset_midflight;
      drive(0, 0, 1, 0, 16'h4000, 0); #1;
      n_vec++; if (bus.D_GNT !== 1'b1) begin n_mis++; $display("FAIL mid_gnt gnt=%b exp 1", bus.D_GNT); end
      @(negedge CLK); drive(0, 0, 0, 0, 0, 0); RST = 1'b1; #1;
      n_vec++; if (bus.D_RVALID !== 1'b0 || bus.D_RD !== 16'h0) begin n_mis++; $display("FAIL mid_drop v=%b rd=%h exp 0 0000", bus.D_RVALID, bus.D_RD); end
      @(negedge CLK); RST = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_vec++; if (bus.D_RVALID !== 1'b0 || bus.IF_RVALID !== 1'b0) begin
            n_mis++; $display("FAIL mid_spurious k=%0d dv=%b ifv=%b exp 0 0", k, bus.D_RVALID, bus.IF_RVALID); end
         @(negedge CLK);
      end
   endtask

   function automatic logic [15:0] pick_addr();
      case ($urandom_range(0, 7))
         0:       return 16'h0000;
         1, 2, 3: return 16'h3000 + 16'($urandom_range(0, 15));
         4:       return 16'h1FF8 + 16'($urandom_range(0, 15));
         5:       return 16'h7FF8 + 16'($urandom_range(0, 15));
         6:       return 16'($urandom);
         default: return 16'h0010 + 16'($urandom_range(0, 3));
      endcase
   endfunction

   task automatic test_random;
      bit ip, dp, dwe, gi, gd, ei, ed, ewe;
      logic [15:0] ia, da, dwd;
      bit xiv, xie, xdv, xde;
      logic [15:0] xird, xdrd;
      int denied;
      ip = 0; dp = 0; dwe = 0; ia = 0; da = 0; dwd = 0;
      xiv = 0; xie = 0; xdv = 0; xde = 0; xird = 0; xdrd = 0; denied = 0;
      drive(0, 0, 0, 0, 0, 0);
      @(negedge CLK); @(negedge CLK);
      for (int c = 0; c <= 600; c++) begin
         if (c < 600) begin
            if (!ip && $urandom_range(0, 9) < 6) begin ip = 1; ia = pick_addr(); end
            if (!dp && $urandom_range(0, 9) < 6) begin dp = 1; dwe = 1'($urandom_range(0, 1)); da = pick_addr(); dwd = 16'($urandom); end
         end else begin
            ip = 0; dp = 0;
         end
         drive(ip, ia, dp, dwe, da, dwd);
         #1;
         n_vec++; if (bus.IF_RVALID !== xiv || bus.IF_ERR !== xie || bus.IF_RD !== xird) begin
            n_mis++; $display("FAIL rnd_if_resp c=%0d v=%b e=%b rd=%h exp %b %b %h", c, bus.IF_RVALID, bus.IF_ERR, bus.IF_RD, xiv, xie, xird); end
         n_vec++; if (bus.D_RVALID !== xdv || bus.D_ERR !== xde || bus.D_RD !== xdrd) begin
            n_mis++; $display("FAIL rnd_d_resp c=%0d v=%b e=%b rd=%h exp %b %b %h", c, bus.D_RVALID, bus.D_ERR, bus.D_RD, xdv, xde, xdrd); end
         gi  = ip && (!dp || denied >= STARVE_MAX);
         gd  = dp && !gi;
         ei  = ia > 16'h8000;
         ed  = (da > 16'h8000) || (dwe && da <= 16'h2000);
         ewe = gd && dwe && !ed;
         n_vec++; if (bus.IF_GNT !== gi || bus.D_GNT !== gd || bus.MEM_WE !== ewe) begin
            n_mis++; $display("FAIL rnd_gnt c=%0d if=%b d=%b we=%b exp %b %b %b", c, bus.IF_GNT, bus.D_GNT, bus.MEM_WE, gi, gd, ewe); end
         if (gi || gd) begin
            n_vec++; if (bus.MEM_A !== (gi ? ia : da)) begin
               n_mis++; $display("FAIL rnd_addr c=%0d a=%h exp %h", c, bus.MEM_A, gi ? ia : da); end
         end
         xiv = gi; xie = gi && ei; xird = (gi && !ei) ? ref_rd(ia) : 16'h0;
         xdv = gd; xde = gd && ed; xdrd = (gd && !dwe && !ed) ? ref_rd(da) : 16'h0;
         if (ewe) ref_mem[da] = dwd;
         denied = (ip && !gi) ? ((denied + 1 > STARVE_MAX) ? STARVE_MAX : denied + 1) : 0;
         if (gi) ip = 0;
         if (gd) dp = 0;
         @(negedge CLK);
      end
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0);
      @(negedge CLK);
      test_reset();
      test_write_read();
      test_starvation();
      test_errors();
      test_reset_midflight();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
